inst_mem_multiport: RTL
=======================

Name: inst_mem_multiport

Overview:
Parametrised successor to the compute unit's combinational instruction ROM.
- Adds registered (1-cycle) multi-port fetch with per-port valid and misalignment flag.
- Adds a streaming program-load port with a valid/ready handshake and an IDLE/LOAD state machine.
- Sits between the warp schedulers / global instruction fetch and the instruction store. Port 0 is conventionally the warp fetch; port NUM_RD_PORTS-1 is the global fetch.

Parameters:
- PC_WIDTH, 8: byte-address width of fetch and load addresses.
- INST_WIDTH, 16: instruction width in bits; instructions are 2-byte aligned.
- DEPTH, 128: number of instruction words; must equal 2^(PC_WIDTH-1).
- NUM_RD_PORTS, 2: number of independent fetch ports, minimum 1.

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- rd_req, input, NUM_RD_PORTS: per-port fetch request.
- rd_addr, input, NUM_RD_PORTS*PC_WIDTH: per-port byte address; port p occupies bits [p*PC_WIDTH +: PC_WIDTH].
- rd_valid, output, NUM_RD_PORTS: per-port response valid, 1-cycle pulse.
- rd_inst, output, NUM_RD_PORTS*INST_WIDTH: per-port instruction word.
- rd_misalign, output, NUM_RD_PORTS: per-port flag; the request address had bit 0 set.
- ld_start, input, 1: begin a program load (sampled only in IDLE).
- ld_base, input, PC_WIDTH: load start byte address; bit 0 ignored.
- ld_count, input, PC_WIDTH: number of instruction words to load.
- ld_valid, input, 1: load data beat valid.
- ld_data, input, INST_WIDTH: load data beat.
- ld_ready, output, 1: block accepts a load beat.
- ld_done, output, 1: 1-cycle pulse; last beat written.
- busy, output, 1: high while in LOAD.

Behaviour:
- Word index = addr[PC_WIDTH-1:1]; DEPTH = 2^(PC_WIDTH-1), so no out-of-range index exists.
- Reset, async on rst high:
  - State -> IDLE.
  - rd_valid, rd_misalign, ld_ready, ld_done, busy = 0; rd_inst = 0.
  - Load pointer and counter = 0.
  - Memory array is NOT cleared; contents persist across reset.
- State IDLE:
  - Each port is independent; all ports may hit the same word in the same cycle.
  - rd_req[p]=1 at edge N -> at edge N+1 rd_valid[p]=1 and rd_inst[p]=mem[idx].
  - rd_req[p]=0 -> rd_valid[p]=0 next cycle; rd_inst[p] holds its last value.
  - Misaligned (addr bit 0 = 1) -> next cycle rd_valid[p]=1, rd_misalign[p]=1, rd_inst[p]=0.
  - ld_start=1 with ld_count != 0:
    - Latch pointer=ld_base[PC_WIDTH-1:1] and remaining=ld_count.
    - Go to LOAD; ld_ready=1 and busy=1 from the next cycle.
  - ld_start=1 with ld_count=0: stay IDLE; ld_done pulses the next cycle; no write.
  - rd_req and ld_start in the same IDLE cycle: the read is serviced normally (response next cycle), then the block enters LOAD.
- State LOAD:
  - rd_req ignored; rd_valid=0 and rd_misalign=0 for all ports.
  - ld_start ignored.
  - Beat accepted when ld_valid && ld_ready: mem[pointer] <= ld_data; pointer increments modulo DEPTH (wraps DEPTH-1 -> 0); remaining decrements.
  - ld_valid=0: no write; state held indefinitely.
  - Last beat accepted (remaining==1) -> next cycle: IDLE, ld_ready=0, busy=0, ld_done=1 for exactly one cycle.
  - ld_count > DEPTH: writes wrap and overwrite earlier words; this is legal and not flagged.
- Write/read ordering:
  - The first fetch issued in the cycle ld_done is high returns newly written data.
  - No read/write collision can occur, since reads are blocked in LOAD.
- Reset mid-load: abort immediately; words already written keep their new values; ld_done is not pulsed.

Test Plan:
- Load 4 words base 0x10 (0xA001, 0xA002, 0xA003, 0xA004), ld_valid continuous:
  - ld_ready high 4 cycles; ld_done pulses once after the 4th beat.
  - Port 0 fetch at 0x14 -> rd_valid next cycle, rd_inst=0xA003.
- Both ports request in the same cycle, port 0 addr 0x10, port 1 addr 0x16:
  - Both rd_valid=1 next cycle with 0xA001 / 0xA004.
  - Same address on both ports -> identical data.
- Port 1 addr 0x11 -> rd_valid=1, rd_misalign=1, rd_inst=0; port 0 unaffected.
- Load count 3, base 0xFC, ld_valid toggled 1/0:
  - Words written at indices 126, 127, 0 (wrap).
  - ld_ready stays 1 while ld_valid stalls; ld_done only after the 3rd accepted beat.
- rd_req asserted during LOAD -> rd_valid stays 0. ld_start with ld_count=0 -> ld_done pulse, busy never rises.
- Assert rst after 2 of 4 load beats:
  - busy, ld_ready, ld_done drop to 0 immediately; state IDLE.
  - Fetch shows the 2 new words plus the old value at the 3rd location.

Source files
------------

// File: rtl/inst_mem_multiport_if.sv
// Fetch and program-load signal bundle for the multi-port instruction memory.
// The master drives requests and load beats; the slave (the memory) answers them.
interface inst_mem_multiport_if #(
    parameter int PC_WIDTH     = 8,
    parameter int INST_WIDTH   = 16,
    parameter int NUM_RD_PORTS = 2
);
    logic [NUM_RD_PORTS-1:0]            rd_req;
    logic [NUM_RD_PORTS*PC_WIDTH-1:0]   rd_addr;
    logic [NUM_RD_PORTS-1:0]            rd_valid;
    logic [NUM_RD_PORTS*INST_WIDTH-1:0] rd_inst;
    logic [NUM_RD_PORTS-1:0]            rd_misalign;
    logic                               ld_start;
    logic [PC_WIDTH-1:0]                ld_base;
    logic [PC_WIDTH-1:0]                ld_count;
    logic                               ld_valid;
    logic [INST_WIDTH-1:0]              ld_data;
    logic                               ld_ready;
    logic                               ld_done;
    logic                               busy;

    modport master (
        output rd_req, rd_addr, ld_start, ld_base, ld_count, ld_valid, ld_data,
        input  rd_valid, rd_inst, rd_misalign, ld_ready, ld_done, busy
    );

    modport slave (
        input  rd_req, rd_addr, ld_start, ld_base, ld_count, ld_valid, ld_data,
        output rd_valid, rd_inst, rd_misalign, ld_ready, ld_done, busy
    );
endinterface

// File: rtl/inst_mem_multiport.sv
// Instruction store with registered multi-port fetch and a streaming program-load
// port. Fetches are serviced only in IDLE, so reads and load writes never collide.
module inst_mem_multiport #(
    parameter int PC_WIDTH     = 8,
    parameter int INST_WIDTH   = 16,
    parameter int DEPTH        = 128,
    parameter int NUM_RD_PORTS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    inst_mem_multiport_if.slave    bus
);
    localparam int IDX_W = PC_WIDTH - 1;

    typedef enum logic {S_IDLE, S_LOAD} state_t;

    logic [INST_WIDTH-1:0] mem [DEPTH];

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   ptr_q, ptr_d;
    logic [PC_WIDTH-1:0]                rem_q, rem_d;
    logic                               ld_ready_q, ld_ready_d;
    logic                               ld_done_q, ld_done_d;
    logic                               busy_q, busy_d;
    logic [NUM_RD_PORTS-1:0]            rd_valid_q, rd_valid_d;
    logic [NUM_RD_PORTS-1:0]            rd_misalign_q, rd_misalign_d;
    logic [NUM_RD_PORTS*INST_WIDTH-1:0] rd_inst_q, rd_inst_d;
    logic                               wr_en;

    // Byte address bit 0 of the load base carries no word information.
    logic unused_ld_base0;
    assign unused_ld_base0 = bus.ld_base[0];

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        ld_done_d     = 1'b0;
        wr_en         = 1'b0;
        rd_valid_d    = '0;
        rd_misalign_d = '0;
        rd_inst_d     = rd_inst_q;

        case (state_q)
            S_IDLE: begin
                for (int p = 0; p < NUM_RD_PORTS; p++) begin
                    if (bus.rd_req[p]) begin
                        rd_valid_d[p]    = 1'b1;
                        rd_misalign_d[p] = bus.rd_addr[p*PC_WIDTH];
                        rd_inst_d[p*INST_WIDTH +: INST_WIDTH] =
                            bus.rd_addr[p*PC_WIDTH] ? '0 : mem[bus.rd_addr[p*PC_WIDTH+1 +: IDX_W]];
                    end
                end
                if (bus.ld_start) begin
                    if (bus.ld_count != '0) begin
                        state_d = S_LOAD;
                        ptr_d   = bus.ld_base[PC_WIDTH-1:1];
                        rem_d   = bus.ld_count;
                    end else begin
                        ld_done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.ld_valid && ld_ready_q) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + IDX_W'(1);
                    rem_d = rem_q - PC_WIDTH'(1);
                    if (rem_q == PC_WIDTH'(1)) begin
                        state_d   = S_IDLE;
                        ld_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        ld_ready_d = (state_d == S_LOAD);
        busy_d     = (state_d == S_LOAD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            rem_q         <= '0;
            ld_ready_q    <= 1'b0;
            ld_done_q     <= 1'b0;
            busy_q        <= 1'b0;
            rd_valid_q    <= '0;
            rd_misalign_q <= '0;
            rd_inst_q     <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            ld_ready_q    <= ld_ready_d;
            ld_done_q     <= ld_done_d;
            busy_q        <= busy_d;
            rd_valid_q    <= rd_valid_d;
            rd_misalign_q <= rd_misalign_d;
            rd_inst_q     <= rd_inst_d;
        end
    end

    // Storage is deliberately outside the reset domain so programs survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= bus.ld_data;
        end
    end

    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_misalign = rd_misalign_q;
    assign bus.rd_inst     = rd_inst_q;
    assign bus.ld_ready    = ld_ready_q;
    assign bus.ld_done     = ld_done_q;
    assign bus.busy        = busy_q;
endmodule
